// File: rtl/mread.sv
`timescale 1ns/1ps
// Memory-read stage: issues aligned MMU reads for loads and partial stores,
// aligns/extends load data and registers all pass-through fields.
module mread (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  output logic        MEM_WAIT,
  output logic        DATA_RDEN,
  output logic [31:0] DATA_RADDR,
  input  logic        DATA_RVALID,
  input  logic [31:0] DATA_RDATA,
  input  logic        EXEC_MEM_R_VALID,
  input  logic [4:0]  EXEC_MEM_R_RD,
  input  logic [31:0] EXEC_MEM_R_ADDR,
  input  logic [3:0]  EXEC_MEM_R_STRB,
  input  logic        EXEC_MEM_R_SIGNED,
  input  logic [4:0]  EXEC_REG_W_RD,
  input  logic [31:0] EXEC_REG_W_DATA,
  input  logic        EXEC_MEM_W_VALID,
  input  logic [31:0] EXEC_MEM_W_ADDR,
  input  logic [3:0]  EXEC_MEM_W_STRB,
  input  logic [31:0] EXEC_MEM_W_DATA,
  output logic        MEMR_MEM_R_VALID,
  output logic [4:0]  MEMR_MEM_R_RD,
  output logic [31:0] MEMR_MEM_R_DATA,
  output logic [4:0]  MEMR_REG_W_RD,
  output logic [31:0] MEMR_REG_W_DATA,
  output logic        MEMR_MEM_W_VALID,
  output logic [31:0] MEMR_MEM_W_ADDR,
  output logic [3:0]  MEMR_MEM_W_STRB,
  output logic [31:0] MEMR_MEM_W_DATA
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  typedef struct packed {
    logic        r_valid;
    logic [4:0]  r_rd;
    logic [31:0] r_data;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [3:0]  m_strb;
    logic [31:0] m_data;
  } out_t;

  typedef struct packed {
    logic        is_load;
    logic [4:0]  rd;
    logic [1:0]  off;
    logic [3:0]  size;
    logic        sgn;
    logic        w_valid;
    logic [31:0] w_addr;
    logic [3:0]  w_strb;
    logic [31:0] w_data;
  } hold_t;

  state_e      state_q, state_d;
  logic        drop_q, drop_d;
  out_t        out_q, out_d;
  hold_t       hold_q, hold_d;
  logic [31:0] buf_q, buf_d;

  logic        partial_st, need_read;
  logic [31:0] rd_addr;

  function automatic logic [31:0] align_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [3:0] size, input logic sgn);
    logic [31:0] sh;
    logic [15:0] hw;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    hw = off[1] ? word[31:16] : word[15:0];
    case (size)
      4'b0001: r = {{24{sgn & sh[7]}}, sh[7:0]};
      4'b0011: r = {{16{sgn & hw[15]}}, hw};
      default: r = word;
    endcase
    return r;
  endfunction

  // Partial stores commit the raw word on the load-data bus for the write stage to merge.
  function automatic out_t commit_out(input hold_t h, input logic [31:0] word);
    out_t o;
    o = '0;
    if (h.is_load) begin
      o.r_valid = 1'b1;
      o.r_rd    = h.rd;
      o.r_data  = align_load(word, h.off, h.size, h.sgn);
    end else begin
      o.r_data  = word;
      o.m_valid = h.w_valid;
      o.m_addr  = h.w_addr;
      o.m_strb  = h.w_strb;
      o.m_data  = h.w_data;
    end
    return o;
  endfunction

  assign partial_st = EXEC_MEM_W_VALID && (EXEC_MEM_W_STRB != 4'b1111) && (EXEC_MEM_W_STRB != 4'b0000);
  assign need_read  = EXEC_MEM_R_VALID | partial_st;
  assign rd_addr    = EXEC_MEM_R_VALID ? EXEC_MEM_R_ADDR : EXEC_MEM_W_ADDR;
  assign DATA_RADDR = rd_addr & 32'hFFFF_FFFC;
  assign MEM_WAIT   = (state_q != S_IDLE) | drop_q;

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    out_d     = out_q;
    hold_d    = hold_q;
    buf_d     = buf_q;
    DATA_RDEN = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (drop_q) begin
          if (DATA_RVALID) drop_d = 1'b0;
          if (!STALL)      out_d  = '0;
        end else if (!STALL) begin
          if (need_read) begin
            DATA_RDEN      = 1'b1;
            hold_d.is_load = EXEC_MEM_R_VALID;
            hold_d.rd      = EXEC_MEM_R_RD;
            hold_d.off     = EXEC_MEM_R_ADDR[1:0];
            hold_d.size    = EXEC_MEM_R_STRB;
            hold_d.sgn     = EXEC_MEM_R_SIGNED;
            hold_d.w_valid = EXEC_MEM_W_VALID;
            hold_d.w_addr  = EXEC_MEM_W_ADDR;
            hold_d.w_strb  = EXEC_MEM_W_STRB;
            hold_d.w_data  = EXEC_MEM_W_DATA;
            out_d          = '0;
            state_d        = S_WAIT;
          end else begin
            out_d         = '0;
            out_d.w_rd    = EXEC_REG_W_RD;
            out_d.w_data  = EXEC_REG_W_DATA;
            out_d.m_valid = EXEC_MEM_W_VALID;
            out_d.m_addr  = EXEC_MEM_W_ADDR;
            out_d.m_strb  = EXEC_MEM_W_STRB;
            out_d.m_data  = EXEC_MEM_W_DATA;
          end
        end
      end
      S_WAIT: begin
        if (DATA_RVALID) begin
          if (!STALL) begin
            out_d   = commit_out(hold_q, DATA_RDATA);
            state_d = S_IDLE;
          end else begin
            buf_d   = DATA_RDATA;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!STALL) begin
          out_d   = commit_out(hold_q, buf_q);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A response arriving in the flush cycle settles the outstanding read, so no drop is needed.
    if (FLUSH) begin
      DATA_RDEN = 1'b0;
      out_d     = '0;
      state_d   = S_IDLE;
      drop_d    = ((state_q == S_WAIT) || drop_q) && !DATA_RVALID;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
      out_q   <= '0;
      hold_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      out_q   <= out_d;
      hold_q  <= hold_d;
      buf_q   <= buf_d;
    end
  end

  assign MEMR_MEM_R_VALID = out_q.r_valid;
  assign MEMR_MEM_R_RD    = out_q.r_rd;
  assign MEMR_MEM_R_DATA  = out_q.r_data;
  assign MEMR_REG_W_RD    = out_q.w_rd;
  assign MEMR_REG_W_DATA  = out_q.w_data;
  assign MEMR_MEM_W_VALID = out_q.m_valid;
  assign MEMR_MEM_W_ADDR  = out_q.m_addr;
  assign MEMR_MEM_W_STRB  = out_q.m_strb;
  assign MEMR_MEM_W_DATA  = out_q.m_data;

endmodule

// File: tb/tb_mread.sv
`timescale 1ns/1ps
// Self-checking bench for mread: directed scenarios plus randomized ops
// against an arithmetic reference for load alignment and commit contents.
module tb_mread;

  logic        CLK = 1'b0;
  logic        RST, STALL, FLUSH;
  logic        MEM_WAIT, DATA_RDEN;
  logic [31:0] DATA_RADDR;
  logic        DATA_RVALID;
  logic [31:0] DATA_RDATA;
  logic        EXEC_MEM_R_VALID;
  logic [4:0]  EXEC_MEM_R_RD;
  logic [31:0] EXEC_MEM_R_ADDR;
  logic [3:0]  EXEC_MEM_R_STRB;
  logic        EXEC_MEM_R_SIGNED;
  logic [4:0]  EXEC_REG_W_RD;
  logic [31:0] EXEC_REG_W_DATA;
  logic        EXEC_MEM_W_VALID;
  logic [31:0] EXEC_MEM_W_ADDR;
  logic [3:0]  EXEC_MEM_W_STRB;
  logic [31:0] EXEC_MEM_W_DATA;
  logic        MEMR_MEM_R_VALID;
  logic [4:0]  MEMR_MEM_R_RD;
  logic [31:0] MEMR_MEM_R_DATA;
  logic [4:0]  MEMR_REG_W_RD;
  logic [31:0] MEMR_REG_W_DATA;
  logic        MEMR_MEM_W_VALID;
  logic [31:0] MEMR_MEM_W_ADDR;
  logic [3:0]  MEMR_MEM_W_STRB;
  logic [31:0] MEMR_MEM_W_DATA;

  int n_checks = 0;
  int n_errors = 0;

  mread dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
    .MEM_WAIT(MEM_WAIT), .DATA_RDEN(DATA_RDEN), .DATA_RADDR(DATA_RADDR),
    .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
    .EXEC_MEM_R_VALID(EXEC_MEM_R_VALID), .EXEC_MEM_R_RD(EXEC_MEM_R_RD),
    .EXEC_MEM_R_ADDR(EXEC_MEM_R_ADDR), .EXEC_MEM_R_STRB(EXEC_MEM_R_STRB),
    .EXEC_MEM_R_SIGNED(EXEC_MEM_R_SIGNED),
    .EXEC_REG_W_RD(EXEC_REG_W_RD), .EXEC_REG_W_DATA(EXEC_REG_W_DATA),
    .EXEC_MEM_W_VALID(EXEC_MEM_W_VALID), .EXEC_MEM_W_ADDR(EXEC_MEM_W_ADDR),
    .EXEC_MEM_W_STRB(EXEC_MEM_W_STRB), .EXEC_MEM_W_DATA(EXEC_MEM_W_DATA),
    .MEMR_MEM_R_VALID(MEMR_MEM_R_VALID), .MEMR_MEM_R_RD(MEMR_MEM_R_RD),
    .MEMR_MEM_R_DATA(MEMR_MEM_R_DATA),
    .MEMR_REG_W_RD(MEMR_REG_W_RD), .MEMR_REG_W_DATA(MEMR_REG_W_DATA),
    .MEMR_MEM_W_VALID(MEMR_MEM_W_VALID), .MEMR_MEM_W_ADDR(MEMR_MEM_W_ADDR),
    .MEMR_MEM_W_STRB(MEMR_MEM_W_STRB), .MEMR_MEM_W_DATA(MEMR_MEM_W_DATA)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_exec;
    EXEC_MEM_R_VALID  = 1'b0;
    EXEC_MEM_R_RD     = '0;
    EXEC_MEM_R_ADDR   = '0;
    EXEC_MEM_R_STRB   = '0;
    EXEC_MEM_R_SIGNED = 1'b0;
    EXEC_REG_W_RD     = '0;
    EXEC_REG_W_DATA   = '0;
    EXEC_MEM_W_VALID  = 1'b0;
    EXEC_MEM_W_ADDR   = '0;
    EXEC_MEM_W_STRB   = '0;
    EXEC_MEM_W_DATA   = '0;
  endtask

  // Reference: select the addressed byte/half by division, then extend by range test.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [3:0] strb, input logic sgn);
    longint unsigned w, v;
    int unsigned     off;
    w   = word;
    off = addr % 4;
    if (strb == 4'b0001) begin
      v = (w / (64'd1 << (8 * off))) % 256;
      if (sgn && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (strb == 4'b0011) begin
      v = (w / (64'd1 << (16 * (off / 2)))) % 65536;
      if (sgn && v >= 32768) v = v + 64'hFFFF_0000;
    end else begin
      v = w;
    end
    return v[31:0];
  endfunction

  task automatic present_load(input logic [31:0] addr, input logic [4:0] rd,
                              input logic [3:0] strb, input logic sgn);
    EXEC_MEM_R_VALID  = 1'b1;
    EXEC_MEM_R_ADDR   = addr;
    EXEC_MEM_R_RD     = rd;
    EXEC_MEM_R_STRB   = strb;
    EXEC_MEM_R_SIGNED = sgn;
  endtask

  task automatic do_pass(input logic [4:0] rd, input logic [31:0] d, input logic st,
                         input logic [31:0] sa, input logic [31:0] sd);
    logic [3:0] ss;
    ss = st ? 4'b1111 : 4'b0000;
    EXEC_REG_W_RD    = rd;
    EXEC_REG_W_DATA  = d;
    EXEC_MEM_W_VALID = st;
    EXEC_MEM_W_ADDR  = sa;
    EXEC_MEM_W_STRB  = ss;
    EXEC_MEM_W_DATA  = sd;
    #1;
    chk("pass_rden", {31'd0, DATA_RDEN}, 32'd0);
    tick;
    clear_exec;
    chk("pass_rvalid", {31'd0, MEMR_MEM_R_VALID}, 32'd0);
    chk("pass_wrd", {27'd0, MEMR_REG_W_RD}, {27'd0, rd});
    chk("pass_wdata", MEMR_REG_W_DATA, d);
    chk("pass_mvalid", {31'd0, MEMR_MEM_W_VALID}, {31'd0, st});
    chk("pass_maddr", MEMR_MEM_W_ADDR, sa);
    chk("pass_mstrb", {28'd0, MEMR_MEM_W_STRB}, {28'd0, ss});
    chk("pass_mdata", MEMR_MEM_W_DATA, sd);
    chk("pass_wait", {31'd0, MEM_WAIT}, 32'd0);
  endtask

  task automatic do_read(input logic is_load, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [3:0] strb, input logic sgn, input logic [31:0] sdata,
                         input logic [31:0] word, input int unsigned lat, input int unsigned stl);
    logic [31:0] exp_data;
    if (is_load) begin
      present_load(addr, rd, strb, sgn);
    end else begin
      EXEC_MEM_W_VALID = 1'b1;
      EXEC_MEM_W_ADDR  = addr;
      EXEC_MEM_W_STRB  = strb;
      EXEC_MEM_W_DATA  = sdata;
    end
    EXEC_REG_W_RD   = 5'($urandom);
    EXEC_REG_W_DATA = $urandom;
    #1;
    chk("rd_rden", {31'd0, DATA_RDEN}, 32'd1);
    chk("rd_raddr", DATA_RADDR, addr - (addr % 4));
    chk("rd_wait0", {31'd0, MEM_WAIT}, 32'd0);
    tick;
    clear_exec;
    chk("rd_wait", {31'd0, MEM_WAIT}, 32'd1);
    chk("rd_rden_off", {31'd0, DATA_RDEN}, 32'd0);
    chk("bub_rvalid", {31'd0, MEMR_MEM_R_VALID}, 32'd0);
    chk("bub_mvalid", {31'd0, MEMR_MEM_W_VALID}, 32'd0);
    chk("bub_wrd", {27'd0, MEMR_REG_W_RD}, 32'd0);
    for (int unsigned i = 1; i < lat; i++) begin
      tick;
      chk("lat_wait", {31'd0, MEM_WAIT}, 32'd1);
      chk("lat_rden", {31'd0, DATA_RDEN}, 32'd0);
    end
    DATA_RVALID = 1'b1;
    DATA_RDATA  = word;
    STALL       = (stl != 0);
    tick;
    DATA_RVALID = 1'b0;
    DATA_RDATA  = $urandom;
    if (stl != 0) begin
      for (int unsigned i = 1; i < stl; i++) begin
        chk("stl_wait", {31'd0, MEM_WAIT}, 32'd1);
        chk("stl_rvalid", {31'd0, MEMR_MEM_R_VALID}, 32'd0);
        chk("stl_mvalid", {31'd0, MEMR_MEM_W_VALID}, 32'd0);
        tick;
      end
      chk("stl_wait_last", {31'd0, MEM_WAIT}, 32'd1);
      chk("stl_rvalid_last", {31'd0, MEMR_MEM_R_VALID}, 32'd0);
      STALL = 1'b0;
      tick;
    end
    exp_data = is_load ? ref_load(word, addr, strb, sgn) : word;
    chk("cm_rvalid", {31'd0, MEMR_MEM_R_VALID}, {31'd0, is_load});
    chk("cm_rrd", {27'd0, MEMR_MEM_R_RD}, is_load ? {27'd0, rd} : 32'd0);
    chk("cm_rdata", MEMR_MEM_R_DATA, exp_data);
    chk("cm_wrd", {27'd0, MEMR_REG_W_RD}, 32'd0);
    chk("cm_mvalid", {31'd0, MEMR_MEM_W_VALID}, {31'd0, !is_load});
    chk("cm_maddr", MEMR_MEM_W_ADDR, is_load ? 32'd0 : addr);
    chk("cm_mstrb", {28'd0, MEMR_MEM_W_STRB}, is_load ? 32'd0 : {28'd0, strb});
    chk("cm_mdata", MEMR_MEM_W_DATA, is_load ? 32'd0 : sdata);
    chk("cm_wait", {31'd0, MEM_WAIT}, 32'd0);
  endtask

  initial begin
    logic [3:0] ld_sz[3];
    logic [3:0] st_sz[6];
    logic [31:0] a, w;
    ld_sz = '{4'b0001, 4'b0011, 4'b1111};
    st_sz = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100};

    RST = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    DATA_RVALID = 1'b0; DATA_RDATA = '0;
    clear_exec;
    tick; tick;
    chk("rst_rvalid", {31'd0, MEMR_MEM_R_VALID}, 32'd0);
    chk("rst_rdata", MEMR_MEM_R_DATA, 32'd0);
    chk("rst_wdata", MEMR_REG_W_DATA, 32'd0);
    chk("rst_maddr", MEMR_MEM_W_ADDR, 32'd0);
    chk("rst_wait", {31'd0, MEM_WAIT}, 32'd0);
    chk("rst_rden", {31'd0, DATA_RDEN}, 32'd0);
    RST = 1'b1;
    tick;

    do_read(1'b1, 32'h100, 5'd5, 4'b1111, 1'b0, 32'd0, 32'hDEADBEEF, 1, 0);
    do_read(1'b1, 32'h103, 5'd7, 4'b0001, 1'b1, 32'd0, 32'h80FF_0000, 2, 0);
    chk("t2_lb", MEMR_MEM_R_DATA, 32'hFFFF_FF80);
    do_read(1'b1, 32'h102, 5'd8, 4'b0011, 1'b0, 32'd0, 32'h80FF_0000, 1, 0);
    chk("t2_lhu", MEMR_MEM_R_DATA, 32'h0000_80FF);
    do_read(1'b1, 32'h103, 5'd8, 4'b0011, 1'b0, 32'd0, 32'h80FF_0000, 3, 0);
    chk("t2_lhu_odd", MEMR_MEM_R_DATA, 32'h0000_80FF);
    do_read(1'b0, 32'h206, 5'd0, 4'b0100, 1'b0, 32'h00AB_0000, 32'h1122_3344, 2, 0);
    chk("t3_raw", MEMR_MEM_R_DATA, 32'h1122_3344);

    do_pass(5'd0, 32'd0, 1'b1, 32'h300, 32'hCAFE_BABE);
    do_pass(5'd3, 32'h42, 1'b0, 32'd0, 32'd0);

    do_read(1'b1, 32'h104, 5'd9, 4'b1111, 1'b0, 32'd0, 32'h0BAD_F00D, 1, 3);

    // STALL in IDLE blocks acceptance and holds the output register.
    STALL = 1'b1;
    present_load(32'h108, 5'd10, 4'b1111, 1'b0);
    #1;
    chk("idle_stall_rden", {31'd0, DATA_RDEN}, 32'd0);
    tick;
    chk("idle_stall_rrd", {27'd0, MEMR_MEM_R_RD}, 32'd9);
    chk("idle_stall_rdata", MEMR_MEM_R_DATA, 32'h0BAD_F00D);
    STALL = 1'b0;
    do_read(1'b1, 32'h108, 5'd10, 4'b1111, 1'b0, 32'd0, 32'h1357_9BDF, 2, 0);

    // FLUSH in WAIT, stale response, new load waiting.
    present_load(32'h400, 5'd11, 4'b1111, 1'b0);
    tick;
    clear_exec;
    tick;
    FLUSH = 1'b1;
    present_load(32'h500, 5'd12, 4'b1111, 1'b0);
    #1;
    chk("fl_rden_flush", {31'd0, DATA_RDEN}, 32'd0);
    tick;
    FLUSH = 1'b0;
    chk("fl_rvalid", {31'd0, MEMR_MEM_R_VALID}, 32'd0);
    chk("fl_wait_drop", {31'd0, MEM_WAIT}, 32'd1);
    chk("fl_rden_drop", {31'd0, DATA_RDEN}, 32'd0);
    tick;
    chk("fl_rden_drop2", {31'd0, DATA_RDEN}, 32'd0);
    DATA_RVALID = 1'b1;
    DATA_RDATA  = 32'hBAD0_BAD0;
    #1;
    chk("fl_rden_stale", {31'd0, DATA_RDEN}, 32'd0);
    tick;
    DATA_RVALID = 1'b0;
    chk("fl_wait_clr", {31'd0, MEM_WAIT}, 32'd0);
    chk("fl_stale_rvalid", {31'd0, MEMR_MEM_R_VALID}, 32'd0);
    chk("fl_stale_rdata", MEMR_MEM_R_DATA, 32'd0);
    do_read(1'b1, 32'h500, 5'd12, 4'b1111, 1'b0, 32'd0, 32'h2468_ACE0, 1, 0);

    // FLUSH in DONE drops the buffered result without setting drop.
    present_load(32'h600, 5'd13, 4'b1111, 1'b0);
    tick;
    clear_exec;
    DATA_RVALID = 1'b1; DATA_RDATA = 32'h7777_7777; STALL = 1'b1;
    tick;
    DATA_RVALID = 1'b0; FLUSH = 1'b1;
    tick;
    FLUSH = 1'b0; STALL = 1'b0;
    chk("fd_wait", {31'd0, MEM_WAIT}, 32'd0);
    chk("fd_rvalid", {31'd0, MEMR_MEM_R_VALID}, 32'd0);
    tick;
    chk("fd_rvalid2", {31'd0, MEMR_MEM_R_VALID}, 32'd0);
    chk("fd_rdata", MEMR_MEM_R_DATA, 32'd0);

    // Asynchronous reset mid-WAIT, then an orphan response must be ignored.
    present_load(32'h700, 5'd14, 4'b1111, 1'b0);
    tick;
    clear_exec;
    chk("ra_wait_pre", {31'd0, MEM_WAIT}, 32'd1);
    #1 RST = 1'b0;
    #1;
    chk("ra_wait", {31'd0, MEM_WAIT}, 32'd0);
    chk("ra_rden", {31'd0, DATA_RDEN}, 32'd0);
    chk("ra_rvalid", {31'd0, MEMR_MEM_R_VALID}, 32'd0);
    tick;
    RST = 1'b1;
    DATA_RVALID = 1'b1; DATA_RDATA = 32'h5A5A_5A5A;
    tick;
    DATA_RVALID = 1'b0;
    chk("ra_orphan_rvalid", {31'd0, MEMR_MEM_R_VALID}, 32'd0);
    chk("ra_orphan_rdata", MEMR_MEM_R_DATA, 32'd0);
    chk("ra_orphan_wait", {31'd0, MEM_WAIT}, 32'd0);

    for (int k = 0; k < 60; k++) begin
      a = $urandom;
      w = $urandom;
      case ($urandom_range(0, 2))
        0: do_pass(5'($urandom), $urandom, 1'($urandom), $urandom, $urandom);
        1: do_read(1'b1, a, 5'($urandom), ld_sz[$urandom_range(0, 2)], 1'($urandom),
                   32'd0, w, $urandom_range(1, 4), $urandom_range(0, 3));
        default: do_read(1'b0, a, 5'd0, st_sz[$urandom_range(0, 5)], 1'b0,
                         $urandom, w, $urandom_range(1, 4), $urandom_range(0, 3));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
